// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_pkg
// Description : Shared state encodings and sync defaults for serial_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    localparam logic [1:0] HUNT   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] PARITY = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    localparam int               DEF_SYNC_LEN     = 4;
    localparam logic [3:0]       DEF_SYNC_PATTERN = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/serial_frame_ctrl_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_detect
// Description : Serial sync-pattern hunter with fill count and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_detect #(
    parameter int                  SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic clear,
    input  logic in,
    output logic match
);

    localparam int HW = SYNC_LEN - 1;
    localparam int FW = $clog2(SYNC_LEN);
    localparam logic [FW-1:0] C_FILL_FULL = FW'(SYNC_LEN - 1);

    // The oldest bit of the comparison window never needs to be stored.
    logic [HW-1:0]       r_hist;
    logic [FW-1:0]       r_fill;
    logic [SYNC_LEN-1:0] w_window;

    assign w_window = {r_hist, in};
    assign match    = (r_fill == C_FILL_FULL) && (w_window == SYNC_PATTERN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift_en) begin
            r_hist <= w_window[HW-1:0];
            if (r_fill != C_FILL_FULL) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_ctrl
// Description : Sync hunt, data/parity shift and valid/ready word hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int                  SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int                  DATA_W       = 8,
    parameter int                  PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              ready,
    output logic              start_shifting,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic [1:0]        cs
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(DATA_W - 1);

    logic [1:0]        r_cs;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_par_err;
    logic              r_start;
    logic              w_match;
    logic              w_hunting;
    logic              w_accept;
    logic [DATA_W-1:0] w_data_next;

    assign w_hunting = (r_cs == HUNT);
    assign w_accept  = (r_cs == HOLD) && ready;

    sync_detect #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_detect (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_hunting),
        .clear    (w_accept),
        .in       (in),
        .match    (w_match)
    );

    generate
        if (DATA_W == 1) begin : g_data_one
            assign w_data_next = in;
        end else begin : g_data_multi
            assign w_data_next = {r_data[DATA_W-2:0], in};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs      <= HUNT;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par_err <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_cs)
                HUNT: begin
                    if (w_match) begin
                        r_cs    <= SHIFT;
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_data <= w_data_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST_BIT) begin
                        r_cs <= (PARITY_EN != 0) ? PARITY : HOLD;
                    end
                end
                PARITY: begin
                    // Odd population across data plus parity bit flags an error.
                    r_par_err <= (^r_data) ^ in;
                    r_cs      <= HOLD;
                end
                HOLD: begin
                    if (ready) begin
                        r_cs <= HUNT;
                    end
                end
                default: r_cs <= HUNT;
            endcase
        end
    end

    assign start_shifting = r_start;
    assign data_out       = r_data;
    assign data_valid     = (r_cs == HOLD);
    assign par_err        = r_par_err;
    assign cs             = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_ctrl
// Description : Directed self-checking bench for serial_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in = 1'b0;
    logic       ready = 1'b1;
    logic       start_shifting;
    logic [7:0] data_out;
    logic       data_valid;
    logic       par_err;
    logic [1:0] cs;

    logic       rst2 = 1'b1;
    logic       in2 = 1'b0;
    logic       ready2 = 1'b1;
    logic       start2;
    logic [7:0] data_out2;
    logic       valid2;
    logic       par_err2;
    logic [1:0] cs2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_frame_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in),
        .ready          (ready),
        .start_shifting (start_shifting),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .cs             (cs)
    );

    serial_frame_ctrl #(
        .SYNC_LEN     (4),
        .SYNC_PATTERN (4'b0000),
        .DATA_W       (8),
        .PARITY_EN    (0)
    ) u_dut_zero (
        .clk            (clk),
        .rst            (rst2),
        .in             (in2),
        .ready          (ready2),
        .start_shifting (start2),
        .data_out       (data_out2),
        .data_valid     (valid2),
        .par_err        (par_err2),
        .cs             (cs2)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit2(input logic b);
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic check_outputs(input string tag, input logic s, input logic [7:0] d,
                                 input logic v, input logic p, input logic [1:0] st);
        check_value({tag, ".start"}, 32'(start_shifting), 32'(s));
        check_value({tag, ".data"},  32'(data_out),       32'(d));
        check_value({tag, ".valid"}, 32'(data_valid),     32'(v));
        check_value({tag, ".perr"},  32'(par_err),        32'(p));
        check_value({tag, ".cs"},    32'(cs),             32'(st));
    endtask

    initial begin
        logic [5:0] hold_bits;
        hold_bits = 6'b110101;

        // Reset state
        #2;
        check_outputs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame 0xA5, good parity, ready high
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check_value("basic.no_early_start", 32'(start_shifting), 32'd0);
        send_bit(1'b1);
        check_value("basic.start", 32'(start_shifting), 32'd1);
        check_value("basic.cs_shift", 32'(cs), 32'd1);
        send_bit(1'b1);
        check_value("basic.start_pulse", 32'(start_shifting), 32'd0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check_value("basic.cs_parity", 32'(cs), 32'd2);
        check_value("basic.valid_low", 32'(data_valid), 32'd0);
        send_bit(1'b0);
        check_outputs("basic.hold", 1'b0, 8'hA5, 1'b1, 1'b0, 2'b11);
        send_bit(1'b0);
        check_value("basic.valid_one_cycle", 32'(data_valid), 32'd0);
        check_value("basic.cs_hunt", 32'(cs), 32'd0);

        // Same frame with a bad parity bit
        send_sync();
        send_byte(8'hA5);
        send_bit(1'b1);
        check_value("perr.data", 32'(data_out), 32'hA5);
        check_value("perr.flag", 32'(par_err), 32'd1);
        check_value("perr.valid", 32'(data_valid), 32'd1);
        send_bit(1'b0);

        // Overlapped sync 1,1,1,0,1 then 0x3C under backpressure
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check_value("ovl.no_start_4", 32'(start_shifting), 32'd0);
        check_value("ovl.cs_hunt_4", 32'(cs), 32'd0);
        send_bit(1'b1);
        check_value("ovl.start_5", 32'(start_shifting), 32'd1);
        send_byte(8'h3C);
        ready = 1'b0;
        send_bit(1'b0);
        check_outputs("bp.rise", 1'b0, 8'h3C, 1'b1, 1'b0, 2'b11);
        for (int i = 5; i >= 0; i--) begin
            send_bit(hold_bits[i]);
            check_outputs("bp.hold", 1'b0, 8'h3C, 1'b1, 1'b0, 2'b11);
        end
        ready = 1'b1;
        send_bit(1'b0);
        check_value("bp.released_valid", 32'(data_valid), 32'd0);
        check_value("bp.released_cs", 32'(cs), 32'd0);
        send_bit(1'b1);
        check_value("bp.no_hunt_in_hold", 32'(start_shifting), 32'd0);
        send_bit(1'b0);

        // Reset after three data bits
        send_sync();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check_value("midrst.cs_shift", 32'(cs), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs("midrst.async", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check_value("midrst.partial_no_match", 32'(cs), 32'd0);
        check_value("midrst.partial_no_start", 32'(start_shifting), 32'd0);
        send_sync();
        check_value("midrst.full_sync", 32'(start_shifting), 32'd1);
        rst = 1'b1;
        #1;

        // All-zero pattern, no parity
        in2 = 1'b0;
        @(posedge clk); #1;
        check_value("zero.reset_valid", 32'(valid2), 32'd0);
        rst2 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            send_bit2(1'b0);
            check_value("zero.no_early_match", 32'(start2), 32'd0);
        end
        send_bit2(1'b0);
        check_value("zero.match_4th", 32'(start2), 32'd1);
        for (int i = 7; i >= 1; i--) begin
            send_bit2(i[0]);
        end
        check_value("zero.valid_not_yet", 32'(valid2), 32'd0);
        send_bit2(1'b0);
        check_value("zero.valid", 32'(valid2), 32'd1);
        check_value("zero.data", 32'(data_out2), 32'hAA);
        check_value("zero.perr", 32'(par_err2), 32'd0);
        check_value("zero.cs", 32'(cs2), 32'd3);
        send_bit2(1'b1);
        check_value("zero.valid_drop", 32'(valid2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Receive-side controller for the serial sync/shift datapath. It hunts the single-bit serial input for a configurable sync pattern, overlaps allowed. On a match it sequences the shift of a fixed-length data word plus an optional even-parity bit. It then holds the assembled word on a valid/ready handshake until the downstream consumer accepts it. It sits between the raw serial line and the word-level consumer, and replaces standalone pattern detectors as the owner of the start_shifting pulse.

## Interface
Parameters:
- SYNC_LEN, 4, sync pattern length in bits (2..8)
- SYNC_PATTERN, 4'b1101, sync pattern, MSB is first bit received
- DATA_W, 8, data bits per frame (1..32), MSB first
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
- clk  in  1  single clock, all flops on rising edge
- rst  in  1  reset, asynchronous, active-high; one clock, no other reset
- in  in  1  serial data, sampled every rising clk edge
- ready  in  1  consumer accepts word when high with data_valid
- start_shifting  out  1  one-cycle pulse, first cycle of SHIFT
- data_out  out  DATA_W  assembled word, stable while data_valid
- data_valid  out  1  word available
- par_err  out  1  parity mismatch for current word; qualified by data_valid; 0 when PARITY_EN=0
- cs  out  2  current state, for debug

## Operation
- State encoding: HUNT=2'b00, SHIFT=2'b01, PARITY=2'b10, HOLD=2'b11.
- Reset values: cs=HUNT, start_shifting=0, data_out=0, data_valid=0, par_err=0. Sync history and fill count are cleared. Bit counter=0.
- HUNT:
  - Each edge shifts `in` into a SYNC_LEN-bit history and increments a saturating fill count.
  - A match means the fill count has reached SYNC_LEN−1 before this edge, and {history[SYNC_LEN-2:0], in} == SYNC_PATTERN.
  - On a match, go to SHIFT with the bit counter set to 0.
  - The fill count prevents false matches on the reset-cleared history, including for an all-zero pattern.
- SHIFT:
  - Each edge does data_out <= {data_out[DATA_W-2:0], in} and increments the bit counter.
  - On the DATA_W-th bit: go to PARITY if PARITY_EN=1, else to HOLD.
  - data_out contents are undefined to the consumer outside HOLD.
- PARITY:
  - One edge samples the parity bit.
  - par_err <= (^data_out) ^ in, i.e. set when the data bits plus parity bit have odd population.
  - Go to HOLD.
- HOLD:
  - data_valid=1; data_out and par_err are frozen; `in` is ignored and not hunted.
  - The edge with ready=1 completes the transfer: go to HUNT, clear the history and fill count, data_valid <= 0.
- A frame with a parity error is still delivered, with par_err=1. The consumer decides what to do with it.
- Mid-frame reset: asynchronous clear to the reset values. A partial frame is discarded. A full SYNC_LEN bits are required again before any match.
- No back-to-back frame capture: sync bits arriving during HOLD are lost. Upstream guarantees idle of at least SYNC_LEN bits between frames, or keeps ready tied high.

## Timing
- Let E0 be the edge that samples the last sync bit.
  - start_shifting=1 during the cycle after E0 only.
  - Data bits are sampled at E1..E(DATA_W).
  - The parity bit is sampled at E(DATA_W+1) when PARITY_EN=1.
- data_valid rises after the final sampling edge: E(DATA_W) without parity, E(DATA_W+1) with parity.
- With ready held high, data_valid is high for exactly one cycle. HUNT resumes sampling on the next edge.
- ready is a don't-care when data_valid=0.
- data_valid does not depend combinationally on ready.
- All outputs are registered or decoded from cs only (Moore). There is no combinational path from `in` or ready to any output.

## Structure
- Shared package serial_frame_pkg holds:
  - the state encodings as localparams HUNT/SHIFT/PARITY/HOLD;
  - the default SYNC_PATTERN and SYNC_LEN values.
- Sub-module sync_detect contains the history register, saturating fill count, comparator and clear input. Parameters: SYNC_LEN, SYNC_PATTERN. Outputs: match, combinational from history and `in`.
- The top level holds the FSM, the bit counter ($clog2(DATA_W+1) bits), the data shift register and the parity flop.

## Test plan
- Basic frame, defaults, ready=1:
  - Stimulus: after reset, in = 1,1,0,1 then 1,0,1,0,0,1,0,1, then parity 0.
  - Response: start_shifting one cycle after the 4th bit; data_out=8'hA5; data_valid high for exactly one cycle, 9 edges after the last sync bit's edge; par_err=0.
- Parity error: same frame with parity bit 1 → data_out=8'hA5, par_err=1, data_valid=1.
- Overlapped sync: in = 1,1,1,0,1 → match at the 5th bit; start_shifting after the 5th edge, not earlier.
- Backpressure:
  - Stimulus: ready=0 for 6 cycles after data_valid rises, in toggling throughout.
  - Response: data_valid, data_out and par_err stable; cs=HOLD. When ready rises, one transfer occurs and cs=HUNT on the next cycle.
- Reset mid-SHIFT: assert rst after 3 data bits → all outputs 0 and cs=HUNT immediately. After release, feeding 1,0,1 does not match; a full 1,1,0,1 is required.
- SYNC_PATTERN=4'b0000, PARITY_EN=0: a run of zeros after reset matches only on the 4th zero. data_valid follows 8 edges later.
